// File: rtl/piezo_sfx_scheduler.sv
// Piezo sound-effect scheduler: latches effect requests, grants by fixed priority with
// preemption, and steps the granted effect's note table. Optional macro: SFX_RETRIGGER_EN.
module piezo_sfx_scheduler #(
  parameter int NOTE_DUR = 300,
  parameter int GAP_DUR  = 50,
  parameter int DIV_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             flush,
  input  logic             mute,
  output logic [DIV_W-1:0] tone_div,
  output logic             busy,
  output logic [3:0]       grant,
  output logic [3:0]       pending,
  output logic             done,
  output logic             abort
);

  localparam int MAX_DUR = (NOTE_DUR > GAP_DUR) ? NOTE_DUR : GAP_DUR;
  localparam int TW      = ($clog2(MAX_DUR + 1) > 16) ? $clog2(MAX_DUR + 1) : 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [3:0]      grant_r, grant_s;
  logic [3:0]      pending_r, pending_s;
  logic [1:0]      eff_r, eff_s;
  logic [2:0]      note_r, note_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic            done_r, done_s;
  logic            abort_r, abort_s;
  logic [1:0]      top_s;
  logic            higher_s;

  // Note code (DO=2, MI=4, SOL=6, silent=0) for a given effect and note index.
  function automatic logic [2:0] note_code(input logic [1:0] eff, input logic [2:0] idx);
    logic [2:0] code;
    case ({eff, idx})
      5'b00_000: code = 3'd2;
      5'b01_000: code = 3'd2;
      5'b01_001: code = 3'd4;
      5'b01_010: code = 3'd6;
      5'b10_000: code = 3'd2;
      5'b10_001: code = 3'd4;
      5'b10_010: code = 3'd6;
      5'b10_011: code = 3'd4;
      5'b10_100: code = 3'd2;
      5'b11_000: code = 3'd2;
      5'b11_010: code = 3'd2;
      5'b11_100: code = 3'd2;
      default:   code = 3'd0;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] effect_len(input logic [1:0] eff);
    logic [2:0] len;
    case (eff)
      2'd0:    len = 3'd1;
      2'd1:    len = 3'd3;
      default: len = 3'd6;
    endcase
    return len;
  endfunction

  function automatic logic [1:0] highest(input logic [3:0] p);
    logic [1:0] idx;
    if (p[3])      idx = 2'd3;
    else if (p[2]) idx = 2'd2;
    else if (p[1]) idx = 2'd1;
    else           idx = 2'd0;
    return idx;
  endfunction

  // Next-state, pending-latch and pulse decode.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    eff_s     = eff_r;
    note_s    = note_r;
    timer_s   = timer_r;
    done_s    = 1'b0;
    abort_s   = 1'b0;
    // A request for the effect already playing never latches.
    pending_s = pending_r | (req & ~grant_r);
    top_s     = highest(pending_r);
    higher_s  = (pending_r != 4'd0) && (top_s > eff_r);

    if (flush) begin
      state_s   = ST_IDLE;
      grant_s   = 4'd0;
      eff_s     = 2'd0;
      note_s    = 3'd0;
      timer_s   = '0;
      pending_s = 4'd0;
      abort_s   = (state_r == ST_PLAY);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pending_r != 4'd0) begin
            state_s = ST_PLAY;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (higher_s) begin
            abort_s = 1'b1;
`ifdef SFX_RETRIGGER_EN
          end else if ((req & grant_r) != 4'd0) begin
            note_s  = 3'd0;
            timer_s = '0;
`endif
          end else if (timer_r == TW'(NOTE_DUR - 1)) begin
            timer_s = '0;
            if (note_r < 3'(effect_len(eff_r) - 3'd1)) begin
              note_s = note_r + 3'd1;
            end else begin
              note_s  = 3'd0;
              done_s  = 1'b1;
              grant_s = 4'd0;
              state_s = ST_GAP;
            end
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
        ST_GAP: begin
          if (pending_r != 4'd0) begin
            state_s = ST_PLAY;
          end else if (timer_r == TW'(GAP_DUR - 1)) begin
            timer_s = '0;
            state_s = ST_IDLE;
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
        default: begin
          state_s = ST_IDLE;
          grant_s = 4'd0;
          timer_s = '0;
          note_s  = 3'd0;
        end
      endcase

      // Fresh grant from IDLE, or a switch out of PLAY/GAP; the granted bit wins over a same-edge set.
      if ((state_r == ST_IDLE && pending_r != 4'd0) ||
          (state_r == ST_PLAY && higher_s) ||
          (state_r == ST_GAP && pending_r != 4'd0)) begin
        grant_s   = 4'b0001 << top_s;
        eff_s     = top_s;
        note_s    = 3'd0;
        timer_s   = '0;
        pending_s = pending_s & ~(4'b0001 << top_s);
      end else begin
        pending_s = pending_s;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      grant_r   <= 4'd0;
      pending_r <= 4'd0;
      eff_r     <= 2'd0;
      note_r    <= 3'd0;
      timer_r   <= '0;
      done_r    <= 1'b0;
      abort_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      pending_r <= pending_s;
      eff_r     <= eff_s;
      note_r    <= note_s;
      timer_r   <= timer_s;
      done_r    <= done_s;
      abort_r   <= abort_s;
    end
  end

  // Divider code from registered state; silent outside PLAY or while muted.
  always_comb begin
    tone_div = '0;
    if (state_r == ST_PLAY && !mute) begin
      tone_div = DIV_W'(note_code(eff_r, note_r));
    end else begin
      tone_div = '0;
    end
  end

  assign busy    = (state_r != ST_IDLE);
  assign grant   = grant_r;
  assign pending = pending_r;
  assign done    = done_r;
  assign abort   = abort_r;

endmodule

// File: tb/tb_piezo_sfx_scheduler.sv
// Bench for piezo_sfx_scheduler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an elapsed-time behavioural model.
module tb_piezo_sfx_scheduler;
  localparam int ND = 4;
  localparam int GD = 2;
`ifdef SFX_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'd0;
  logic       flush = 1'b0;
  logic       mute = 1'b0;
  logic [9:0] tone_div;
  logic       busy, done, abort;
  logic [3:0] grant, pending;

  int n_checks = 0;
  int n_err = 0;

  piezo_sfx_scheduler #(.NOTE_DUR(ND), .GAP_DUR(GD), .DIV_W(10)) dut (
    .clk(clk), .rst(rst), .req(req), .flush(flush), .mute(mute),
    .tone_div(tone_div), .busy(busy), .grant(grant), .pending(pending),
    .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  // Effect tables as plain arrays.
  int tbl [4][6] = '{'{2,0,0,0,0,0}, '{2,4,6,0,0,0}, '{2,4,6,4,2,0}, '{2,0,2,0,2,0}};
  int len [4] = '{1, 3, 6, 6};

  // Model: active effect, cycles elapsed in it, remaining gap cycles.
  logic [3:0] m_pend;
  int         m_act, m_el, m_gap;
  bit         m_done, m_abort;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic f);
    logic [3:0] gm, nxt;
    int top, start;
    gm = (m_act >= 0) ? (4'b0001 << m_act) : 4'b0000;
    top = -1;
    start = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i]) top = i;
    m_done = 1'b0;
    m_abort = 1'b0;
    if (f) begin
      m_abort = (m_act >= 0);
      m_pend = 4'd0; m_act = -1; m_gap = 0; m_el = 0;
    end else begin
      nxt = m_pend | (r & ~gm);
      if (m_act >= 0) begin
        if (top > m_act) begin
          start = top; m_abort = 1'b1;
        end else if (RETRIG && (r & gm) != 4'd0) begin
          m_el = 0;
        end else begin
          m_el++;
          if (m_el == len[m_act] * ND) begin
            m_done = 1'b1; m_act = -1; m_gap = GD;
          end
        end
      end else if (m_gap > 0) begin
        if (top >= 0) start = top;
        else m_gap--;
      end else if (top >= 0) begin
        start = top;
      end
      if (start >= 0) begin
        m_act = start; m_el = 0; m_gap = 0; nxt[start] = 1'b0;
      end
      m_pend = nxt;
    end
  endtask

  // Model advance on every edge, reset asynchronously with the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = 4'd0; m_act = -1; m_el = 0; m_gap = 0; m_done = 1'b0; m_abort = 1'b0;
    end else begin
      model_step(req, flush);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("grant",   grant,   (m_act >= 0) ? (1 << m_act) : 0);
      chk("pending", pending, m_pend);
      chk("busy",    busy,    (m_act >= 0 || m_gap > 0) ? 1 : 0);
      chk("done",    done,    m_done);
      chk("abort",   abort,   m_abort);
      chk("tone_div", tone_div, (m_act >= 0 && !mute) ? tbl[m_act][m_el / ND] : 0);
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input logic [3:0] r);
    req = r;
    cyc();
    req = 4'd0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || pending != 4'd0) && k < 200) begin
      cyc();
      k++;
    end
    chk("idle_timeout", (k < 200) ? 1 : 0, 1);
  endtask

  // Count edges until done pulses; returns -1 on timeout.
  task automatic cycles_to_done(input int start, output int n);
    n = start;
    while (!done && n < 200) begin
      cyc();
      n++;
    end
    if (!done) n = -1;
  endtask

  int n;

  initial begin
    cyc(2);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tone", tone_div, 0);
    chk("rst_pending", pending, 0);
    rst = 1'b1;
    cyc();

    // Single click: pending, then grant with DO for ND cycles, done, gap.
    pulse(4'b0001);
    chk("click_pend", pending, 1);
    chk("click_nogrant", grant, 0);
    cyc();
    chk("click_grant", grant, 1);
    chk("click_tone", tone_div, 2);
    chk("click_pend_clr", pending, 0);
    cyc(3);
    chk("click_still", grant, 1);
    cyc();
    chk("click_done", done, 1);
    chk("click_gap_busy", busy, 1);
    cyc();
    chk("click_gap2", busy, 1);
    cyc();
    chk("click_idle", busy, 0);

    // Preempt eff1 during its second note with eff3.
    pulse(4'b0010);
    cyc(5);
    chk("pre_note2", tone_div, 4);
    pulse(4'b1000);
    chk("pre_pend", pending, 8);
    cyc();
    chk("pre_abort", abort, 1);
    chk("pre_grant", grant, 8);
    chk("pre_tone", tone_div, 2);
    cycles_to_done(0, n);
    chk("pre_done_cycles", n, 24);
    wait_idle();

    // Simultaneous eff2+eff0: eff2 first, eff0 kept pending.
    pulse(4'b0101);
    cyc();
    chk("sim_grant", grant, 4);
    chk("sim_pend", pending, 1);
    mute = 1'b1;
    cyc(2);
    chk("mute_tone", tone_div, 0);
    mute = 1'b0;
    cycles_to_done(2, n);
    chk("mute_done_cycles", n, 24);
    cyc(2);
    chk("sim_second", grant, 1);
    wait_idle();

    // Repeated req[2] six edges into eff2.
    pulse(4'b0100);
    cyc();
    cyc(5);
    pulse(4'b0100);
    chk("retrig_pend", pending, 0);
    cycles_to_done(6, n);
    chk("retrig_done_cycles", n, RETRIG ? 30 : 24);
    wait_idle();

    // Flush during eff3 with a same-edge request.
    pulse(4'b1000);
    cyc(3);
    req = 4'b0010;
    flush = 1'b1;
    cyc();
    req = 4'd0;
    flush = 1'b0;
    chk("flush_abort", abort, 1);
    chk("flush_pend", pending, 0);
    chk("flush_grant", grant, 0);
    chk("flush_busy", busy, 0);
    chk("flush_nodone", done, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      req   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      flush = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) mute = ~mute;
      if (c == 1500) begin
        rst = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pend", pending, 0);
        cyc();
        rst = 1'b1;
      end
      cyc();
    end
    req = 4'd0;
    flush = 1'b0;
    mute = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
